// File: rtl/alu_result_stage.sv
// Registered ALU result stage: computes status flags on accept and holds them,
// with the result, in a two-entry skid buffer behind a valid/ready handshake.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_sel,
  input  logic             in_carry,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] acc_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_e;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             accept, transfer;

  assign accept   = in_valid & in_ready_q;
  assign transfer = out_valid & out_ready;

  // Flags are derived from the raw ALU sideband at accept time.
  always_comb begin
    new_e        = '0;
    new_e.result = in_result;
    new_e.zero   = (in_result == '0);
    new_e.neg    = in_result[WIDTH-1];
    case (in_sel)
      2'b10: begin
        new_e.carry = in_carry;
        new_e.ovf   = (in_a_msb == in_b_msb) & (in_result[WIDTH-1] != in_a_msb);
      end
      2'b11: begin
        new_e.carry = in_carry;
        new_e.ovf   = (in_a_msb != in_b_msb) & (in_result[WIDTH-1] != in_a_msb);
      end
      default: begin
        new_e.carry = 1'b0;
        new_e.ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = new_e;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          main_d = new_e;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = new_e;
        end else if (transfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (transfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: looks at the next state, so no path from out_ready.
    in_ready_d = (state_d != TWO);
    acc_d      = (accept && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
  end

  always_comb begin
    out_valid  = (state_q != EMPTY);
    in_ready   = in_ready_q;
    out_result = main_q.result;
    out_zero   = main_q.zero;
    out_neg    = main_q.neg;
    out_carry  = main_q.carry;
    out_ovf    = main_q.ovf;
    acc_count  = acc_q;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit ALU result mux; consumes the selected 32-bit result plus the 2-bit op select that drove it.
- Computes status flags (zero, negative, carry, overflow) and holds them in an output register.
- Uses a valid/ready handshake with a 2-entry skid buffer so that downstream back-pressure never drops or reorders a result.

Parameters:
- WIDTH, 32, data width of result and operand MSB taps.
- CNT_W, 16, width of the saturating accepted-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept; registered
- in_result  input  WIDTH  ALU mux output
- in_sel  input  2  op select: 00 AND, 01 OR, 10 ADD, 11 SUB
- in_carry  input  1  adder carry-out, raw with no borrow inversion
- in_a_msb  input  1  operand A bit WIDTH-1
- in_b_msb  input  1  operand B bit WIDTH-1, before SUB inversion
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  registered result
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1]
- out_carry  output  1  carry flag
- out_ovf  output  1  signed overflow flag
- acc_count  output  CNT_W  number of results accepted, saturating

Behaviour:
- Synchronous active-high reset applies to clk.
- Reset values:
  - out_valid=0, out_result=0, all flags 0, acc_count=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - State returns to EMPTY.
- Accept = in_valid & in_ready at a rising edge. Transfer = out_valid & out_ready at a rising edge.
- Flags are computed at accept and stored alongside the result in the entry:
  - zero = (result == 0); neg = result MSB.
  - sel 00/01: carry=0, ovf=0.
  - sel 10 (ADD): carry = in_carry; ovf = (a_msb == b_msb) & (r_msb != a_msb).
  - sel 11 (SUB): carry = in_carry; ovf = (a_msb != b_msb) & (r_msb != a_msb).
- Storage: main register (drives out_*) plus one skid register.
- States:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE; data goes to main.
  - ONE: out_valid=1, in_ready=1.
    - Accept & transfer → ONE; main is replaced by the new entry.
    - Accept & no transfer → TWO; new entry goes to skid.
    - Transfer & no accept → EMPTY.
    - Neither → hold.
  - TWO: out_valid=1, in_ready=0.
    - Transfer → ONE; skid moves to main.
    - No transfer → hold.
- Latency: an accept in EMPTY presents out_valid on the next cycle (1-cycle latency).
- Throughput: 1 result per cycle while out_ready stays high.
- in_ready is a register output; it has no combinational path from out_ready.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_* values and flags are stable while out_valid=1 & out_ready=0.
- in_valid while in_ready=0 is ignored. Upstream must hold its data; the stage does not capture it.
- acc_count increments on each accept and saturates at 2^CNT_W-1 (no wrap).
- rst asserted mid-operation: all entries are discarded on that edge, and all outputs and acc_count return to their reset values on the next cycle.

Test Plan:
- Reset then single ADD: result=0x00000000, sel=10, carry=1, a_msb=1, b_msb=1 → one cycle later out_valid=1, zero=1, neg=0, carry=1, ovf=1; acc_count=1.
- Overflow on ADD and SUB:
  - ADD 0x7FFFFFFF+1, result=0x80000000, a_msb=0, b_msb=0 → ovf=1, neg=1.
  - SUB with a_msb=1, b_msb=0, result=0x7FFFFFFF → ovf=1.
  - AND or OR with the same msbs → ovf=0, carry=0.
- Back-pressure:
  - Hold out_ready=0 and drive 3 back-to-back results 0x11, 0x22, 0x33.
  - Required: 0x11 and 0x22 accepted; in_ready falls after the second accept; 0x33 is not taken.
  - Then out_ready=1 → outputs 0x11, 0x22, 0x33 in order with no gaps once 0x33 is re-offered.
- Streaming: out_ready=1, 100 consecutive results → 100 transfers, each 1 cycle after its accept; in_ready stays 1 throughout; acc_count=100.
- Reset mid-operation: fill to TWO, assert rst for 1 cycle → out_valid=0, in_ready=0 during rst, in_ready=1 the cycle after, acc_count=0, no stale data emitted.
- Saturation: with CNT_W=4, perform 20 accepts → acc_count=15 and stays at 15.
